// File: rtl/mp_sequencer.sv
// Start/done sequencer for the shift-add multiplier datapath; one add/shift iteration per multiplier bit.
// Optional build macro EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mp_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       q_lsb,
    input  logic       q_zero,
    input  logic       n_zero,
    output logic [1:0] b_sel,
    output logic [1:0] q_sel,
    output logic [1:0] a_sel,
    output logic [1:0] n_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_TEST, S_ADD, S_SHIFT, S_CHECK, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(WIDTH);
    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_OP   = 2'b01;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             err_q, err_d;

`ifndef EARLY_EXIT_EN
    logic unused_q_zero;
    assign unused_q_zero = q_zero;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        err_d   = err_q;
        b_sel   = SEL_HOLD;
        q_sel   = SEL_HOLD;
        a_sel   = SEL_HOLD;
        n_sel   = SEL_HOLD;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                b_sel   = SEL_LOAD;
                q_sel   = SEL_LOAD;
                a_sel   = SEL_LOAD;
                n_sel   = SEL_LOAD;
                busy    = 1'b1;
                iter_d  = '0;
                err_d   = 1'b0;
                state_d = S_TEST;
            end
            S_TEST: begin
                busy = 1'b1;
`ifdef EARLY_EXIT_EN
                if (q_zero)     state_d = S_DONE;
                else if (q_lsb) state_d = S_ADD;
                else            state_d = S_SHIFT;
`else
                state_d = q_lsb ? S_ADD : S_SHIFT;
`endif
            end
            S_ADD: begin
                a_sel   = SEL_OP;
                busy    = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                b_sel   = SEL_OP;
                q_sel   = SEL_OP;
                n_sel   = SEL_OP;
                busy    = 1'b1;
                // Saturate so a runaway datapath counter cannot wrap our count back into range.
                iter_d  = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (n_zero || iter_q == ITER_MAX) begin
                    state_d = S_DONE;
                    if (!(n_zero && iter_q == ITER_MAX)) err_d = 1'b1;
                end else begin
                    state_d = S_TEST;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err = err_q;

endmodule
